score_counter: RTL and testbench



---
 rtl/scoreboard_pkg.sv | 23 ++
 rtl/score_counter_if.sv | 23 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/score_counter.sv | 129 ++++++++++++
 tb/tb_score_counter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_pkg.sv
// Shared score/display constants: digit-select one-hots, 7-segment glyphs
// (bit0=a .. bit6=g, active high) and the BCD digit type.
package scoreboard_pkg;

  localparam int unsigned BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;

  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/score_counter_if.sv
// Signal bundle around score_counter: pulse requests in, score and
// multiplexed display out. master = stimulus side, slave = counter side.
interface score_counter_if;

  logic                  count_up;
  logic                  count_down;
  scoreboard_pkg::bcd_t  score_tens;
  scoreboard_pkg::bcd_t  score_ones;
  logic                  score_changed;
  logic [6:0]            seg;
  logic [1:0]            digit_sel;

  modport master (
    output count_up, count_down,
    input  score_tens, score_ones, score_changed, seg, digit_sel
  );

  modport slave (
    input  count_up, count_down,
    output score_tens, score_ones, score_changed, seg, digit_sel
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder; non-decimal codes blank the digit.
module seg7_decoder
  import scoreboard_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_counter.sv
// Two-digit BCD score driven by up/down pulse rising edges, with a 2-digit
// multiplexed 7-segment display. Define SCORE_WRAP_EN to wrap at the bounds.
module score_counter
  import scoreboard_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 5000,
  parameter int unsigned MAX_SCORE   = 99
) (
  input  logic       clk_1mhz,
  input  logic       rst_n,
  input  logic       count_up_i,
  input  logic       count_down_i,
  output bcd_t       score_tens_o,
  output bcd_t       score_ones_o,
  output logic       score_changed_o,
  output logic [6:0] seg_o,
  output logic [1:0] digit_sel_o
);

  localparam bcd_t        MAX_TENS = bcd_t'(MAX_SCORE / 10);
  localparam bcd_t        MAX_ONES = bcd_t'(MAX_SCORE % 10);
  localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);

  logic        r_up_prev, r_dn_prev;
  bcd_t        r_tens, r_ones;
  logic        r_changed;
  logic [15:0] r_refresh;
  logic [1:0]  r_sel;
  logic [6:0]  r_seg;

  logic        w_up_evt, w_dn_evt;
  logic        w_at_max, w_at_zero;
  bcd_t        w_tens_nxt, w_ones_nxt;
  logic        w_change;
  logic        w_slot_end;
  logic [1:0]  w_sel_nxt;
  bcd_t        w_dig;
  logic [6:0]  w_seg;

  assign w_up_evt  = count_up_i & ~r_up_prev;
  assign w_dn_evt  = count_down_i & ~r_dn_prev;
  assign w_at_max  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
  assign w_at_zero = (r_tens == '0) && (r_ones == '0);

  always_comb begin
    w_tens_nxt = r_tens;
    w_ones_nxt = r_ones;
    w_change   = 1'b0;
    if (w_up_evt && !w_dn_evt) begin
      if (w_at_max) begin
`ifdef SCORE_WRAP_EN
        w_tens_nxt = '0;
        w_ones_nxt = '0;
        w_change   = 1'b1;
`endif
      end else begin
        w_change = 1'b1;
        if (r_ones == 4'd9) begin
          w_ones_nxt = '0;
          w_tens_nxt = r_tens + 4'd1;
        end else begin
          w_ones_nxt = r_ones + 4'd1;
        end
      end
    end else if (w_dn_evt && !w_up_evt) begin
      if (w_at_zero) begin
`ifdef SCORE_WRAP_EN
        w_tens_nxt = MAX_TENS;
        w_ones_nxt = MAX_ONES;
        w_change   = 1'b1;
`endif
      end else begin
        w_change = 1'b1;
        if (r_ones == '0) begin
          w_ones_nxt = 4'd9;
          w_tens_nxt = r_tens - 4'd1;
        end else begin
          w_ones_nxt = r_ones - 4'd1;
        end
      end
    end
  end

  // Prev registers reset high so a button already held at release is not a press.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_up_prev <= 1'b1;
      r_dn_prev <= 1'b1;
      r_tens    <= '0;
      r_ones    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_up_prev <= count_up_i;
      r_dn_prev <= count_down_i;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_changed <= w_change;
    end
  end

  assign w_slot_end = (r_refresh == REF_LAST);
  assign w_sel_nxt  = w_slot_end ? {r_sel[0], r_sel[1]} : r_sel;
  // Decode against the next selection so segments and enable move together.
  assign w_dig      = (w_sel_nxt == DIG_TENS) ? r_tens : r_ones;

  seg7_decoder u_dec (
    .i_bcd (w_dig),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_sel     <= DIG_ONES;
      r_seg     <= SEG_0;
    end else begin
      r_refresh <= w_slot_end ? '0 : r_refresh + 16'd1;
      r_sel     <= w_sel_nxt;
      r_seg     <= w_seg;
    end
  end

  assign score_tens_o    = r_tens;
  assign score_ones_o    = r_ones;
  assign score_changed_o = r_changed;
  assign seg_o           = r_seg;
  assign digit_sel_o     = r_sel;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: dut A (REFRESH_DIV=4, MAX 99) and
// dut B (MAX_SCORE=20). Expectations follow SCORE_WRAP_EN when defined.
module tb_score_counter;

  logic clk_1mhz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_1mhz = ~clk_1mhz;

  score_counter_if ifa ();
  score_counter_if ifb ();

  score_counter #(.REFRESH_DIV(4), .MAX_SCORE(99)) dut_a (
    .clk_1mhz        (clk_1mhz),
    .rst_n           (rst_n),
    .count_up_i      (ifa.count_up),
    .count_down_i    (ifa.count_down),
    .score_tens_o    (ifa.score_tens),
    .score_ones_o    (ifa.score_ones),
    .score_changed_o (ifa.score_changed),
    .seg_o           (ifa.seg),
    .digit_sel_o     (ifa.digit_sel)
  );

  score_counter #(.REFRESH_DIV(5000), .MAX_SCORE(20)) dut_b (
    .clk_1mhz        (clk_1mhz),
    .rst_n           (rst_n),
    .count_up_i      (ifb.count_up),
    .count_down_i    (ifb.count_down),
    .score_tens_o    (ifb.score_tens),
    .score_ones_o    (ifb.score_ones),
    .score_changed_o (ifb.score_changed),
    .seg_o           (ifb.seg),
    .digit_sel_o     (ifb.digit_sel)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobes_a = 0;
  int strobes_b = 0;

  always @(negedge clk_1mhz) begin
    if (ifa.score_changed === 1'b1) strobes_a++;
    if (ifb.score_changed === 1'b1) strobes_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1mhz);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  // which: 0 = A up, 1 = A down, 2 = B up
  task automatic pulse(input int which, input int hold);
    case (which)
      0: ifa.count_up   = 1'b1;
      1: ifa.count_down = 1'b1;
      default: ifb.count_up = 1'b1;
    endcase
    tick(hold);
    ifa.count_up   = 1'b0;
    ifa.count_down = 1'b0;
    ifb.count_up   = 1'b0;
    tick(4);
  endtask

  initial begin
    int base;
    logic [1:0] prev_sel;
    logic [1:0] first_sel;
    logic [1:0] exp_sel;
    logic found;

    ifa.count_up = 1'b1; ifa.count_down = 1'b0;
    ifb.count_up = 1'b0; ifb.count_down = 1'b0;
    tick(5);
    check("rst_tens",    32'(ifa.score_tens), 32'd0);
    check("rst_ones",    32'(ifa.score_ones), 32'd0);
    check("rst_changed", 32'(ifa.score_changed), 32'd0);
    check("rst_sel",     32'(ifa.digit_sel), 32'b01);
    check("rst_seg",     32'(ifa.seg), 32'b0111111);

    // Up already high at release: ignored.
    base = strobes_a;
    rst_n = 1'b1;
    tick(1000);
    check("held_tens",    32'(ifa.score_tens), 32'd0);
    check("held_ones",    32'(ifa.score_ones), 32'd0);
    check("held_strobes", 32'(strobes_a - base), 32'd0);

    ifa.count_up = 1'b0;
    tick(10);
    base = strobes_a;
    ifa.count_up = 1'b1;
    tick(1);
    check("lat_ones",    32'(ifa.score_ones), 32'd1);
    check("lat_changed", 32'(ifa.score_changed), 32'd1);
    tick(1);
    check("strobe_once", 32'(ifa.score_changed), 32'd0);
    tick(998);
    ifa.count_up = 1'b0;
    tick(10);
    check("rerise_score",   32'({ifa.score_tens, ifa.score_ones}), 32'h01);
    check("rerise_strobes", 32'(strobes_a - base), 32'd1);

    // Eleven long up pulses from 00.
    do_reset();
    base = strobes_a;
    for (int i = 1; i <= 11; i++) begin
      pulse(0, 1000);
      if (i == 9)  check("up9",  32'({ifa.score_tens, ifa.score_ones}), 32'h09);
      if (i == 10) check("up10", 32'({ifa.score_tens, ifa.score_ones}), 32'h10);
    end
    check("up11",         32'({ifa.score_tens, ifa.score_ones}), 32'h11);
    check("up11_strobes", 32'(strobes_a - base), 32'd11);

    // Down at 00.
    do_reset();
    base = strobes_a;
    pulse(1, 1000);
`ifdef SCORE_WRAP_EN
    check("dn_at_0",         32'({ifa.score_tens, ifa.score_ones}), 32'h99);
    check("dn_at_0_strobes", 32'(strobes_a - base), 32'd1);
`else
    check("dn_at_0",         32'({ifa.score_tens, ifa.score_ones}), 32'h00);
    check("dn_at_0_strobes", 32'(strobes_a - base), 32'd0);
`endif

    // Up at 99 (A) and at 20 (B).
    do_reset();
    for (int i = 0; i < 99; i++) pulse(0, 2);
    check("reach99", 32'({ifa.score_tens, ifa.score_ones}), 32'h99);
    base = strobes_a;
    pulse(0, 1000);
`ifdef SCORE_WRAP_EN
    check("up_at_99",         32'({ifa.score_tens, ifa.score_ones}), 32'h00);
    check("up_at_99_strobes", 32'(strobes_a - base), 32'd1);
`else
    check("up_at_99",         32'({ifa.score_tens, ifa.score_ones}), 32'h99);
    check("up_at_99_strobes", 32'(strobes_a - base), 32'd0);
`endif
    for (int i = 0; i < 20; i++) pulse(2, 2);
    check("reach20", 32'({ifb.score_tens, ifb.score_ones}), 32'h20);
    base = strobes_b;
    pulse(2, 50);
`ifdef SCORE_WRAP_EN
    check("up_at_20",         32'({ifb.score_tens, ifb.score_ones}), 32'h00);
    check("up_at_20_strobes", 32'(strobes_b - base), 32'd1);
`else
    check("up_at_20",         32'({ifb.score_tens, ifb.score_ones}), 32'h20);
    check("up_at_20_strobes", 32'(strobes_b - base), 32'd0);
`endif

    // Simultaneous edges at 05, then up rising while down held.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(0, 2);
    base = strobes_a;
    ifa.count_up = 1'b1; ifa.count_down = 1'b1;
    tick(5);
    check("both_score",   32'({ifa.score_tens, ifa.score_ones}), 32'h05);
    check("both_strobes", 32'(strobes_a - base), 32'd0);
    ifa.count_up = 1'b0;
    tick(3);
    ifa.count_up = 1'b1;
    tick(1);
    check("up_dn_held",         32'({ifa.score_tens, ifa.score_ones}), 32'h06);
    check("up_dn_held_changed", 32'(ifa.score_changed), 32'd1);
    ifa.count_up = 1'b0; ifa.count_down = 1'b0;
    tick(4);

    // Display multiplex at 37 with REFRESH_DIV=4.
    do_reset();
    for (int i = 0; i < 37; i++) pulse(0, 2);
    check("reach37", 32'({ifa.score_tens, ifa.score_ones}), 32'h37);
    prev_sel = ifa.digit_sel;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (ifa.digit_sel !== prev_sel) found = 1'b1;
    end
    check("slot_edge_found", 32'(found), 32'd1);
    first_sel = ifa.digit_sel;
    for (int k = 0; k < 8; k++) begin
      exp_sel = (k < 4) ? first_sel : {first_sel[0], first_sel[1]};
      check("mux_sel", 32'(ifa.digit_sel), 32'(exp_sel));
      check("mux_seg", 32'(ifa.seg), (exp_sel == 2'b01) ? 32'b0000111 : 32'b1001111);
      tick(1);
    end

    // Asynchronous reset in the middle of a tens slot.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ifa.digit_sel === 2'b10) found = 1'b1;
      else tick(1);
    end
    check("tens_slot_found", 32'(found), 32'd1);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("async_sel",   32'(ifa.digit_sel), 32'b01);
    check("async_seg",   32'(ifa.seg), 32'b0111111);
    check("async_score", 32'({ifa.score_tens, ifa.score_ones}), 32'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
